// File: rtl/grayscale_pkg.sv
// Shared definitions for the RGB565 grayscale stream: mode encoding, luma
// weight sets and the 565-to-888 channel expansion helpers.
package grayscale_pkg;

    localparam logic [1:0] MODE_BT709 = 2'd0;
    localparam logic [1:0] MODE_BT601 = 2'd1;
    localparam logic [1:0] MODE_AVG   = 2'd2;
    localparam logic [1:0] MODE_GREEN = 2'd3;

    localparam int WEIGHT_W  = 9;
    localparam int PRODUCT_W = 17;

    typedef struct packed {
        logic [WEIGHT_W-1:0] wr;
        logic [WEIGHT_W-1:0] wg;
        logic [WEIGHT_W-1:0] wb;
    } weights_t;

    // Each weight set sums to 256, so the rounded result always fits in a byte.
    localparam weights_t W_BT709 = '{wr: 9'd54, wg: 9'd183, wb: 9'd19};
    localparam weights_t W_BT601 = '{wr: 9'd77, wg: 9'd150, wb: 9'd29};
    localparam weights_t W_AVG   = '{wr: 9'd85, wg: 9'd86,  wb: 9'd85};
    localparam weights_t W_GREEN = '{wr: 9'd0,  wg: 9'd256, wb: 9'd0};

    function automatic weights_t mode_weights(input logic [1:0] mode);
        weights_t w;
        case (mode)
            MODE_BT709: w = W_BT709;
            MODE_BT601: w = W_BT601;
            MODE_AVG:   w = W_AVG;
            default:    w = W_GREEN;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

endpackage

// File: rtl/rgb565_luma_lane.sv
// One pixel's luma pipeline: stage 1 holds the weighted channel products,
// stage 2 holds the rounded gray byte. Both stages stall when enable is low.
module rgb565_luma_lane
    import grayscale_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        valid_i,
    input  logic [1:0]  mode_i,
    input  logic [15:0] pixel_i,
    output logic        valid_o,
    output logic [7:0]  gray_o
);

    weights_t               w_d;
    logic [PRODUCT_W-1:0]   prod_r_d, prod_g_d, prod_b_d;
    logic [PRODUCT_W-1:0]   prod_r_q, prod_g_q, prod_b_q;
    logic [PRODUCT_W-1:0]   sum_d;
    logic                   sum_msb_unused;
    logic [7:0]             sum_frac_unused;
    logic [7:0]             gray_d;
    logic                   valid1_q, valid2_q;
    logic [7:0]             gray_q;

    always_comb begin
        w_d      = mode_weights(mode_i);
        prod_r_d = {8'd0, w_d.wr} * {9'd0, expand5(pixel_i[15:11])};
        prod_g_d = {8'd0, w_d.wg} * {9'd0, expand6(pixel_i[10:5])};
        prod_b_d = {8'd0, w_d.wb} * {9'd0, expand5(pixel_i[4:0])};
    end

    // Weights sum to 256, so bit 16 of the rounded sum is always zero.
    always_comb begin
        sum_d = prod_r_q + prod_g_q + prod_b_q + 17'd128;
        {sum_msb_unused, gray_d, sum_frac_unused} = sum_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            gray_q   <= '0;
        end else if (enable) begin
            valid1_q <= valid_i;
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            valid2_q <= valid1_q;
            gray_q   <= gray_d;
        end
    end

    assign valid_o = valid2_q;
    assign gray_o  = gray_q;

endmodule

// File: rtl/rgb565_grayscale_stream.sv
// Streaming RGB565 to 8-bit gray converter: PIXELS lanes feed a packer that
// assembles OUT_PIXELS-byte words, flushing partial words on end of frame.
module rgb565_grayscale_stream
    import grayscale_pkg::*;
#(
    parameter int PIXELS     = 2,
    parameter int OUT_PIXELS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [16*PIXELS-1:0]    s_data,
    input  logic [1:0]              s_mode,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [8*OUT_PIXELS-1:0] m_data,
    output logic [OUT_PIXELS-1:0]   m_keep,
    output logic                    m_last
);

    localparam int BEATS  = OUT_PIXELS / PIXELS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W = 8 * PIXELS;
    localparam int WORD_W = 8 * OUT_PIXELS;

    generate
        if (PIXELS < 1 || OUT_PIXELS < PIXELS || (OUT_PIXELS % PIXELS) != 0) begin : g_bad_cfg
            $error("OUT_PIXELS must be a positive multiple of PIXELS");
        end
    endgenerate

    logic                advance;
    logic                s_fire;
    logic [PIXELS-1:0]   lane_valid;
    logic [BEAT_W-1:0]   beat_gray;
    logic                stage2_valid;
    logic                last1_q, last2_q;

    logic [CNT_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   pack_data_q, pack_data_d;
    logic [OUT_PIXELS-1:0] pack_keep_q, pack_keep_d;
    logic [WORD_W-1:0]   word_data;
    logic [OUT_PIXELS-1:0] word_keep;
    logic                m_valid_q, m_valid_d;
    logic [WORD_W-1:0]   m_data_q, m_data_d;
    logic [OUT_PIXELS-1:0] m_keep_q, m_keep_d;
    logic                m_last_q, m_last_d;

    // The whole pipeline moves as one; only a held output word stalls it.
    assign advance = !(m_valid_q && !m_ready);
    assign s_ready = advance && !reset;
    assign s_fire  = s_valid && s_ready;

    genvar gi;
    generate
        for (gi = 0; gi < PIXELS; gi++) begin : g_lane
            rgb565_luma_lane u_lane (
                .clock   (clock),
                .reset   (reset),
                .enable  (advance),
                .valid_i (s_fire),
                .mode_i  (s_mode),
                .pixel_i (s_data[16*gi +: 16]),
                .valid_o (lane_valid[gi]),
                .gray_o  (beat_gray[8*gi +: 8])
            );
        end
    endgenerate

    assign stage2_valid = &lane_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            last1_q <= 1'b0;
            last2_q <= 1'b0;
        end else if (advance) begin
            last1_q <= s_fire && s_last;
            last2_q <= last1_q;
        end
    end

    // Merge the stage-2 beat into its slot of the word under construction.
    always_comb begin
        word_data = pack_data_q;
        word_keep = pack_keep_q;
        for (int b = 0; b < BEATS; b++) begin
            if (count_q == CNT_W'(b)) begin
                word_data[b*BEAT_W +: BEAT_W] = beat_gray;
                word_keep[b*PIXELS +: PIXELS] = '1;
            end
        end
    end

    always_comb begin
        count_d     = count_q;
        pack_data_d = pack_data_q;
        pack_keep_d = pack_keep_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        if (advance) begin
            m_valid_d = 1'b0;
            if (stage2_valid) begin
                if (count_q == CNT_W'(BEATS - 1) || last2_q) begin
                    m_valid_d   = 1'b1;
                    m_data_d    = word_data;
                    m_keep_d    = word_keep;
                    m_last_d    = last2_q;
                    count_d     = '0;
                    pack_data_d = '0;
                    pack_keep_d = '0;
                end else begin
                    count_d     = count_q + CNT_W'(1);
                    pack_data_d = word_data;
                    pack_keep_d = word_keep;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            pack_data_q <= '0;
            pack_keep_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            pack_data_q <= pack_data_d;
            pack_keep_q <= pack_keep_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;

endmodule
